eth_frame_loop_tx: RTL and testbench

ETH_FRAME_LOOP_TX -- requirements
Module: eth_frame_loop_tx

---
 rtl/eth_frame_loop_tx.sv | 188 ++++++++++++++++++
 tb/tb_eth_frame_loop_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_loop_tx.sv
// Frame loopback transmit path: per-byte script ops from a latched lane,
// optional CRC-32 FCS regeneration, oversize truncation, fixed 2-cycle latency.
module eth_frame_loop_tx #(
  parameter int unsigned C_NUM_SCRIPTS    = 4,
  parameter int unsigned C_MAX_FRAME_SIZE = 2048,
  localparam int unsigned SEL_W  = (C_NUM_SCRIPTS > 1) ? $clog2(C_NUM_SCRIPTS) : 1,
  localparam int unsigned USER_W = 32 * C_NUM_SCRIPTS + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  script_sel,
  input  logic              fcs_recompute,
  input  logic [7:0]        s_axis_tdata,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  output logic [31:0]       frame_count,
  output logic [31:0]       drop_count
);

  localparam int unsigned CNT_W = $clog2(C_MAX_FRAME_SIZE + 1);

  localparam logic [2:0] OP_REPL = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_DROP = 3'd6;
  localparam logic [2:0] OP_BAD  = 3'd7;

  typedef enum logic [2:0] {ST_SYNC, ST_IDLE, ST_FRAME, ST_FCS, ST_DISCARD} state_t;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  state_t           state;
  logic [SEL_W-1:0] sel_q;
  logic             fcs_rec_q;
  logic [CNT_W-1:0] byte_cnt;
  logic [2:0]       fcs_idx;

  logic       s1_valid, s1_first, s1_last, s1_trunc, s1_fcs, s1_rep, s1_bad_in;
  logic [7:0] s1_data, s1_param;
  logic [2:0] s1_op;
  logic [1:0] s1_k;

  logic [31:0] crc;
  logic        bad_acc;

  logic             start_c, accept_c, trunc_c, fcs_rec_c;
  logic [SEL_W-1:0] sel_raw_c, lane_c;
  logic [2:0]       op_c, fcs_idx_c;
  logic [7:0]       param_c;
  logic [CNT_W-1:0] cnt_next_c;
  logic             unused_tuser_c;

  assign unused_tuser_c = ^s_axis_tuser;

  // Input-side decode: first byte of a frame uses live controls, later bytes the latched ones
  always_comb begin
    start_c    = (state == ST_IDLE);
    accept_c   = s_axis_tvalid && (state == ST_IDLE || state == ST_FRAME || state == ST_FCS);
    sel_raw_c  = start_c ? script_sel : sel_q;
    lane_c     = (32'(sel_raw_c) < C_NUM_SCRIPTS) ? sel_raw_c : '0;
    fcs_rec_c  = start_c ? fcs_recompute : fcs_rec_q;
    fcs_idx_c  = start_c ? 3'd0 : fcs_idx;
    cnt_next_c = start_c ? CNT_W'(1) : byte_cnt + CNT_W'(1);
    trunc_c    = !start_c && !s_axis_tlast && (cnt_next_c == CNT_W'(C_MAX_FRAME_SIZE));
    op_c       = '0;
    param_c    = '0;
    for (int i = 0; i < C_NUM_SCRIPTS; i++) begin
      if (lane_c == SEL_W'(i)) begin
        op_c    = s_axis_tuser[3 + 32 * i +: 3];
        param_c = s_axis_tuser[3 + 32 * i + 16 +: 8];
      end
    end
  end

  // Frame-tracking FSM and first pipeline stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_SYNC;
      sel_q     <= '0;
      fcs_rec_q <= 1'b0;
      byte_cnt  <= '0;
      fcs_idx   <= '0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_trunc  <= 1'b0;
      s1_fcs    <= 1'b0;
      s1_rep    <= 1'b0;
      s1_bad_in <= 1'b0;
      s1_data   <= '0;
      s1_param  <= '0;
      s1_op     <= '0;
      s1_k      <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) begin
        s1_first  <= start_c;
        s1_data   <= s_axis_tdata;
        s1_last   <= s_axis_tlast || trunc_c;
        s1_trunc  <= trunc_c;
        s1_op     <= op_c;
        s1_param  <= param_c;
        s1_fcs    <= s_axis_tuser[2];
        s1_rep    <= s_axis_tuser[2] && fcs_rec_c && (fcs_idx_c < 3'd4);
        s1_k      <= fcs_idx_c[1:0];
        s1_bad_in <= s_axis_tuser[0];
        sel_q     <= lane_c;
        fcs_rec_q <= fcs_rec_c;
        byte_cnt  <= cnt_next_c;
        fcs_idx   <= (s_axis_tuser[2] && fcs_idx_c < 3'd4) ? fcs_idx_c + 3'd1 : fcs_idx_c;
        if (s_axis_tlast)                            state <= ST_IDLE;
        else if (trunc_c)                            state <= ST_DISCARD;
        else if (s_axis_tuser[2] || state == ST_FCS) state <= ST_FCS;
        else                                         state <= ST_FRAME;
      end else begin
        case (state)
          ST_SYNC:    if (!s_axis_tvalid || s_axis_tlast) state <= ST_IDLE;
          ST_DISCARD: if (s_axis_tvalid && s_axis_tlast)  state <= ST_IDLE;
          default:    state <= state;
        endcase
      end
    end
  end

  logic [31:0] crc_cur_c, crc_inv_c;
  logic [7:0]  src_c, res_c;
  logic        drop_c, bad_c;

  // Second stage: FCS substitution, byte op, frame-bad accumulation
  always_comb begin
    crc_cur_c = s1_first ? 32'hFFFF_FFFF : crc;
    crc_inv_c = ~crc_cur_c;
    src_c     = s1_rep ? crc_inv_c[{s1_k, 3'b000} +: 8] : s1_data;
    case (s1_op)
      OP_REPL: res_c = s1_param;
      OP_XOR:  res_c = src_c ^ s1_param;
      OP_AND:  res_c = src_c & s1_param;
      OP_OR:   res_c = src_c | s1_param;
      OP_ADD:  res_c = src_c + s1_param;
      default: res_c = src_c;
    endcase
    drop_c = (s1_op == OP_DROP) && !s1_last;
    bad_c  = (s1_first ? 1'b0 : bad_acc) | s1_bad_in | (s1_op == OP_BAD) | s1_trunc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc           <= '0;
      bad_acc       <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      frame_count   <= '0;
      drop_count    <= '0;
    end else begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      if (s1_valid) begin
        bad_acc <= bad_c;
        crc     <= (s1_fcs || drop_c) ? crc_cur_c : crc_step(crc_cur_c, res_c);
        if (drop_c) begin
          drop_count <= drop_count + 32'd1;
        end else begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= res_c;
          m_axis_tlast  <= s1_last;
          m_axis_tuser  <= s1_last && bad_c;
          if (s1_last) frame_count <= frame_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_loop_tx.sv
// Directed scoreboard bench for eth_frame_loop_tx: expected beats carry their
// due cycle so latency, gaps and content are checked together.
module tb_eth_frame_loop_tx;

  localparam int unsigned NS   = 3;
  localparam int unsigned MAXF = 16;
  localparam int unsigned SW   = 2;
  localparam int unsigned UW   = 32 * NS + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] script_sel = '0;
  logic          fcs_recompute = 1'b0;
  logic [7:0]    s_axis_tdata = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tuser, m_axis_tlast, m_axis_tvalid;
  logic [31:0]   frame_count, drop_count;

  eth_frame_loop_tx #(.C_NUM_SCRIPTS(NS), .C_MAX_FRAME_SIZE(MAXF)) dut (
    .clk(clk), .rst(rst), .script_sel(script_sel), .fcs_recompute(fcs_recompute),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .frame_count(frame_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned t;
    logic [7:0]  d;
    logic        l;
    logic        u;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  logic        mon_en = 1'b0;
  logic [7:0]  held_exp = 8'h00;

  always @(posedge clk) begin
    cyc++;
    if (rst) held_exp = 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [UW-1:0] mk_user(input int lane, input logic [2:0] op,
                                            input logic [7:0] prm, input logic fa, input logic bad);
    logic [UW-1:0] u;
    u = '0;
    u[0] = bad;
    u[1] = fa;
    u[2] = fa;
    u[3 + 32 * lane +: 8]      = {5'b10110, op};
    u[3 + 32 * lane + 8 +: 8]  = 8'hA5;
    u[3 + 32 * lane + 16 +: 8] = prm;
    u[3 + 32 * lane + 24 +: 8] = 8'h5A;
    return u;
  endfunction

  // Output monitor: pops the scoreboard on every emitted beat, polices idle slots
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_axis_tvalid === 1'b1) begin
        chk("beat_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", cyc, e.t);
          chk("tdata", {24'h0, m_axis_tdata}, {24'h0, e.d});
          chk("tlast", 32'(m_axis_tlast), 32'(e.l));
          chk("tuser", 32'(m_axis_tuser), 32'(e.u));
          held_exp = e.d;
        end
      end else begin
        chk("idle_tlast", 32'(m_axis_tlast), 32'd0);
        chk("idle_hold", {24'h0, m_axis_tdata}, {24'h0, held_exp});
        if (sb.size() != 0 && sb[0].t <= cyc) begin
          chk("beat_in_slot", 32'(m_axis_tvalid), 32'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic beat(input logic [7:0] d, input logic [UW-1:0] u, input logic last,
                      input logic [SW-1:0] sel, input logic frec,
                      input logic emit, input logic [7:0] ed, input logic el, input logic eu);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = last;
    script_sel    = sel;
    fcs_recompute = frec;
    if (emit) sb.push_back('{cyc + 2, ed, el, eu});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = 8'h00;
      s_axis_tuser  = '0;
    end
  endtask

  initial begin
    logic [7:0] fcs_exp[4];
    fcs_exp = '{8'h26, 8'h39, 8'hF4, 8'hCB};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", {24'h0, m_axis_tdata}, 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tuser", 32'(m_axis_tuser), 32'd0);
    chk("rst_frame_count", frame_count, 32'd0);
    chk("rst_drop_count", drop_count, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // "123456789" + regenerated FCS; fcs_recompute drops mid-frame but stays latched
    for (int i = 0; i < 9; i++)
      beat(8'(8'h31 + i), mk_user(0, 3'd0, 8'h00, 1'b0, 1'b0), 1'b0, 2'd0, (i == 0),
           1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      beat(8'h00, mk_user(0, 3'd0, 8'h00, 1'b1, 1'b0), (k == 3), 2'd0, 1'b0,
           1'b1, fcs_exp[k], (k == 3), 1'b0);
    idle(4);
    chk("frame_count_1", frame_count, 32'd1);

    // Replace / XOR / ADD on lane 2; lane 0 holds a decoy op, sel changes after byte 1
    beat(8'h10, mk_user(2, 3'd1, 8'h55, 0, 0) | mk_user(0, 3'd1, 8'hEE, 0, 0), 1'b0, 2'd2, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    beat(8'h20, mk_user(2, 3'd2, 8'hFF, 0, 0) | mk_user(0, 3'd1, 8'hEE, 0, 0), 1'b0, 2'd0, 1'b0, 1'b1, 8'hDF, 1'b0, 1'b0);
    beat(8'h30, mk_user(2, 3'd5, 8'hF0, 0, 0) | mk_user(0, 3'd1, 8'hEE, 0, 0), 1'b1, 2'd0, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0);
    idle(4);
    chk("frame_count_2", frame_count, 32'd2);

    // Drop on byte 2 leaves a gap; drop on the tlast byte is ignored
    beat(8'hA0, mk_user(1, 3'd0, 8'h00, 0, 0), 1'b0, 2'd1, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b0);
    beat(8'hA1, mk_user(1, 3'd6, 8'h00, 0, 0), 1'b0, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    beat(8'hA2, mk_user(1, 3'd0, 8'h00, 0, 0), 1'b0, 2'd1, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b0);
    beat(8'hA3, mk_user(1, 3'd0, 8'h00, 0, 0), 1'b0, 2'd1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0);
    beat(8'hA4, mk_user(1, 3'd6, 8'h00, 0, 0), 1'b1, 2'd1, 1'b0, 1'b1, 8'hA4, 1'b1, 1'b0);
    idle(4);
    chk("drop_count_1", drop_count, 32'd1);
    chk("frame_count_3", frame_count, 32'd3);

    // AND / OR / mark-bad, input FRAME_BAD early and on a single-byte frame, out-of-range sel
    beat(8'hF0, mk_user(1, 3'd3, 8'h3C, 0, 0), 1'b0, 2'd1, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
    beat(8'h0F, mk_user(1, 3'd4, 8'h50, 0, 0), 1'b0, 2'd1, 1'b0, 1'b1, 8'h5F, 1'b0, 1'b0);
    beat(8'h77, mk_user(1, 3'd7, 8'h00, 0, 0), 1'b1, 2'd1, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
    beat(8'h01, mk_user(0, 3'd0, 8'h00, 0, 1), 1'b0, 2'd0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    beat(8'h02, mk_user(0, 3'd0, 8'h00, 0, 0), 1'b1, 2'd0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1);
    beat(8'h5A, mk_user(0, 3'd0, 8'h00, 0, 1), 1'b1, 2'd0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1);
    beat(8'h11, mk_user(0, 3'd2, 8'h0F, 0, 0), 1'b1, 2'd3, 1'b0, 1'b1, 8'h1E, 1'b1, 1'b0);
    idle(4);
    chk("frame_count_7", frame_count, 32'd7);

    // Oversize frame truncated at 16 bytes, followed by a normal frame
    for (int i = 0; i < 20; i++)
      beat(8'(i), mk_user(0, 3'd0, 8'h00, 0, 0), (i == 19), 2'd0, 1'b0,
           (i < 16), 8'(i), (i == 15), (i == 15));
    beat(8'hE1, mk_user(0, 3'd0, 8'h00, 0, 0), 1'b0, 2'd0, 1'b0, 1'b1, 8'hE1, 1'b0, 1'b0);
    beat(8'hE2, mk_user(0, 3'd0, 8'h00, 0, 0), 1'b1, 2'd0, 1'b0, 1'b1, 8'hE2, 1'b1, 1'b0);
    idle(4);
    chk("frame_count_9", frame_count, 32'd9);

    // Reset on byte 5 of a back-to-back stream; rest of that frame must vanish
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      rst           = (i == 4);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(8'h80 + i);
      s_axis_tuser  = mk_user(0, 3'd0, 8'h00, 0, 0);
      s_axis_tlast  = (i == 9);
      if (i < 3) sb.push_back('{cyc + 2, 8'(8'h80 + i), 1'b0, 1'b0});
    end
    beat(8'hC1, mk_user(0, 3'd0, 8'h00, 0, 0), 1'b0, 2'd0, 1'b0, 1'b1, 8'hC1, 1'b0, 1'b0);
    beat(8'hC2, mk_user(0, 3'd0, 8'h00, 0, 0), 1'b0, 2'd0, 1'b0, 1'b1, 8'hC2, 1'b0, 1'b0);
    beat(8'hC3, mk_user(0, 3'd0, 8'h00, 0, 0), 1'b1, 2'd0, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0);
    idle(5);
    chk("frame_count_after_rst", frame_count, 32'd1);
    chk("drop_count_after_rst", drop_count, 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
